logic_regfile: RTL
==================

// Module: logic_regfile
// PURPOSE
//  Register file for the single-cycle datapath. Its two read ports drive the A/B
//  operand inputs of the 8-bit logical (AND/OR) unit. Its write port takes that
//  unit's Y result back at the end of the cycle. It also holds the Z/N status flags
//  that the branch logic and heart-rate threshold compare read. Reads are
//  combinational; writes and flag updates occur on the rising clock edge.
// PARAMETERS
//  WIDTH    8  data width of each register and of all data ports
//  ADDR_W   3  address width; register count = 2**ADDR_W (8)
//  R0_ZERO  1  1: register 0 is hardwired to zero, writes to it discarded; 0: normal
// PORTS
//  clk       in   1       system clock; all state updates on rising edge
//  rst_n     in   1       synchronous reset, active-low; sampled on rising edge of clk
//  ra_addr   in   ADDR_W  read port A address
//  rb_addr   in   ADDR_W  read port B address
//  a_data    out  WIDTH   contents of reg[ra_addr] -> logical unit A
//  b_data    out  WIDTH   contents of reg[rb_addr] -> logical unit B
//  wr_en     in   1       write strobe for this cycle
//  wr_addr   in   ADDR_W  write destination
//  wr_data   in   WIDTH   write data (logical unit Y)
//  flag_en   in   1       update Z/N flags from wr_data this cycle
//  flag_z    out  1       registered zero flag
//  flag_n    out  1       registered negative flag (MSB of last flagged result)
//  wr_count  out  8       saturating count of committed register writes (debug)
// BEHAVIOUR
//  Reset
//   - Synchronous, active-low. When rst_n=0 at a rising edge, set all registers,
//     flag_z, flag_n and wr_count to 0.
//   - Reset has priority over wr_en and flag_en in the same cycle.
//   - A write in progress while reset is asserted is dropped.
//  Reads
//   - a_data/b_data are purely combinational from the stored array.
//   - No write-to-read bypass. A read of wr_addr returns the old value until the
//     edge that commits the write, so the A/B -> Y -> wr_data path has no comb loop.
//   - With R0_ZERO=1, reads of address 0 return 0 regardless of array contents.
//   - ra_addr may equal rb_addr: both ports return the same value.
//  Writes
//   - Commit occurs when rst_n=1 and wr_en=1 at a rising edge:
//     reg[wr_addr] <= wr_data.
//   - With R0_ZERO=1 and wr_addr=0, the register write is discarded.
//     wr_count does not increment; flags still follow flag_en.
//   - wr_en=0 leaves every register unchanged. wr_addr/wr_data are don't-care.
//   - wr_count increments by 1 per committed write and saturates at 8'hFF (no wrap).
//  Flags
//   - Update occurs when rst_n=1 and flag_en=1 at a rising edge:
//     flag_z <= (wr_data == 0); flag_n <= wr_data[WIDTH-1].
//   - flag_en does not depend on wr_en; with wr_en=0 the flags still update from
//     wr_data (compare-only operation).
//   - flag_en=0: flags hold.
//  Latency
//   - Write-to-read: 1 cycle. Data written at edge k is visible on a_data/b_data
//     combinationally after edge k.
//   - Flags: visible after the same edge.
//  Boundaries
//   - Consecutive writes to the same address: last write wins, one per edge.
//   - Address values are always in range (2**ADDR_W registers); no error path.
//   - X on wr_data with wr_en=0 must not corrupt state.
// TESTING
//  1 Reset
//    Stimulus: write reg3=8'hA5, then hold rst_n=0 for one edge with wr_en=1,
//    wr_data=8'h77.
//    Required: all reads 0, flag_z=0, flag_n=0, wr_count=0.
//  2 Write/read and latency
//    Stimulus: wr_en=1, wr_addr=5, wr_data=8'h3C; ra_addr=rb_addr=5.
//    Required: a_data shows old 8'h00 before the edge and 8'h3C after it on both ports.
//  3 R0 hardwire (R0_ZERO=1)
//    Stimulus: write 8'hFF to address 0 with flag_en=1.
//    Required: a_data(ra=0)=8'h00, wr_count unchanged, flag_z=0, flag_n=1.
//  4 Flags only
//    Stimulus: wr_en=0, flag_en=1, wr_data=8'h00.
//    Required: flag_z=1, flag_n=0, no register changed.
//    Then flag_en=0 with wr_data=8'h80: flags hold.
//  5 Closed loop with logical unit
//    Stimulus: reg1=8'hF0, reg2=8'h3C; OP=1 (AND); ra=1, rb=2; write Y to reg3.
//    Required: reg3=8'h30, flag_z=0.
//    Then OP=0 (OR), write to reg4: reg4=8'hFC, flag_n=1.
//  6 Saturation and back-to-back writes
//    Stimulus: 300 consecutive writes alternating addresses 6 and 7.
//    Required: wr_count=8'hFF; reg6/reg7 hold the final data written to each.

Source files
------------

// File: rtl/logic_regfile.sv
`default_nettype none
// ============================================================================
// Module   : logic_regfile
// Purpose  : Register file feeding the A/B operands of the 8-bit logical unit.
//            Two combinational read ports, one write port committed on the
//            rising clock edge, Z/N status flags, and a saturating write
//            counter for debug.
// Revision : 1.0 - initial release
// ============================================================================
module logic_regfile #(
  parameter int WIDTH   = 8,
  parameter int ADDR_W  = 3,
  parameter int R0_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [WIDTH-1:0]  a_data,
  output logic [WIDTH-1:0]  b_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              flag_en,
  output logic              flag_z,
  output logic              flag_n,
  output logic [7:0]        wr_count
);

  localparam int         c_DEPTH   = 2 ** ADDR_W;
  localparam logic [7:0] c_CNT_MAX = 8'hFF;

  logic [WIDTH-1:0] r_mem [c_DEPTH];
  logic             r_flag_z;
  logic             r_flag_n;
  logic [7:0]       r_wr_count;

  logic             w_dest_is_r0;
  logic             w_commit;

  // A write to address 0 is discarded when register 0 is hardwired to zero.
  assign w_dest_is_r0 = (R0_ZERO != 0) && (wr_addr == '0);
  assign w_commit     = wr_en && !w_dest_is_r0;

  // Register array, flags and write counter; reset wins over any write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_flag_z   <= 1'b0;
      r_flag_n   <= 1'b0;
      r_wr_count <= '0;
    end else begin
      if (w_commit) begin
        r_mem[wr_addr] <= wr_data;
        if (r_wr_count != c_CNT_MAX) begin
          r_wr_count <= r_wr_count + 8'd1;
        end
      end
      // Flags are independent of wr_en so a compare-only cycle updates them.
      if (flag_en) begin
        r_flag_z <= (wr_data == '0);
        r_flag_n <= wr_data[WIDTH-1];
      end
    end
  end

  // Combinational reads with no write bypass, so A/B -> Y -> wr_data has no loop.
  always_comb begin
    a_data = r_mem[ra_addr];
    b_data = r_mem[rb_addr];
    if ((R0_ZERO != 0) && (ra_addr == '0)) begin
      a_data = '0;
    end
    if ((R0_ZERO != 0) && (rb_addr == '0)) begin
      b_data = '0;
    end
  end

  assign flag_z   = r_flag_z;
  assign flag_n   = r_flag_n;
  assign wr_count = r_wr_count;

endmodule
`default_nettype wire
